// File: rtl/axi_ram_pkg.sv
// Shared constants and state types for the AXI4 RAM responder.
package axi_ram_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_4B = 3'b010;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  // WRAP and the reserved encoding are walked as INCR but flagged in the response.
  function automatic logic burst_resp_err(input logic [2:0] size, input logic [1:0] burst);
    return (size != SIZE_4B) || (burst == BURST_WRAP) || (burst == 2'b11);
  endfunction

endpackage

// File: rtl/axi_ram_array.sv
// Word-addressed RAM: one byte-enabled write port, one registered read port.
module axi_ram_array #(
  parameter int C_MEM_WORDS_LOG2 = 10
) (
  input  logic                        clk_sys,
  input  logic                        rst_b,
  input  logic                        wr_en,
  input  logic [C_MEM_WORDS_LOG2-1:0] wr_idx,
  input  logic [31:0]                 wr_data,
  input  logic [3:0]                  wr_strb,
  input  logic                        rd_en,
  input  logic [C_MEM_WORDS_LOG2-1:0] rd_idx,
  output logic [31:0]                 rd_data
);

  logic [31:0] mem [0:(1<<C_MEM_WORDS_LOG2)-1];

  // Storage is never reset so a mid-burst reset keeps already written beats.
  always_ff @(posedge clk_sys) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b)     rd_data <= 32'h0;
    else if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/axi_ram_responder.sv
// AXI4 slave RAM with independent single-burst write and read engines.
// state   | meaning
// W_IDLE  | AWREADY high, waiting for a write address
// W_DATA  | WREADY high, one beat written per handshake until beat AWLEN
// W_RESP  | BVALID high until BREADY
// R_IDLE  | ARREADY high, waiting for a read address
// R_FETCH | RAM read of the current beat into the RDATA register
// R_DATA  | RVALID high, beat held until RREADY
module axi_ram_responder
  import axi_ram_pkg::*;
#(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_MEM_WORDS_LOG2   = 10
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic [2:0]                      S_AXI_AWSIZE,
  input  logic [1:0]                      S_AXI_AWBURST,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic [2:0]                      S_AXI_ARSIZE,
  input  logic [1:0]                      S_AXI_ARBURST,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int IW = C_MEM_WORDS_LOG2;

  w_state_t w_state, w_state_next;
  r_state_t r_state, r_state_next;

  logic                        aw_ready_q, ar_ready_q;
  logic                        aw_hs, ar_hs, w_hs, r_hs;
  logic                        wready, bvalid, rvalid, rd_en;

  logic [C_S_AXI_ID_WIDTH-1:0] w_id, r_id;
  logic [IW-1:0]               w_idx, r_idx;
  logic [7:0]                  w_len, w_cnt, r_len, r_cnt;
  logic                        w_err, w_size_err, w_fixed, w_last_err;
  logic                        r_err, r_size_err, r_fixed, r_last;
  logic [31:0]                 ram_rdata;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:IW+2], S_AXI_AWADDR[1:0],
                              S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:IW+2], S_AXI_ARADDR[1:0]};

  assign aw_hs  = S_AXI_AWVALID && aw_ready_q;
  assign ar_hs  = S_AXI_ARVALID && ar_ready_q;
  assign r_last = (r_cnt == r_len);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_state_next;
      r_state <= r_state_next;
    end
  end

  always_comb begin
    w_state_next = w_state;
    wready       = 1'b0;
    bvalid       = 1'b0;
    w_hs         = 1'b0;
    case (w_state)
      W_IDLE: if (aw_hs) w_state_next = W_DATA;
      W_DATA: begin
        wready = 1'b1;
        w_hs   = S_AXI_WVALID;
        // Burst length comes from AWLEN only; WLAST merely feeds the error flag.
        if (S_AXI_WVALID && (w_cnt == w_len)) w_state_next = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (S_AXI_BREADY) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_next = r_state;
    rvalid       = 1'b0;
    rd_en        = 1'b0;
    r_hs         = 1'b0;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_next = R_FETCH;
      R_FETCH: begin
        rd_en        = 1'b1;
        r_state_next = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        r_hs   = S_AXI_RREADY;
        if (S_AXI_RREADY) r_state_next = r_last ? R_IDLE : R_FETCH;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_ready_q <= 1'b0;
      w_id       <= '0;
      w_idx      <= '0;
      w_len      <= 8'd0;
      w_cnt      <= 8'd0;
      w_err      <= 1'b0;
      w_size_err <= 1'b0;
      w_fixed    <= 1'b0;
      w_last_err <= 1'b0;
    end else begin
      // Registered ready, so it only rises one edge after reset release.
      aw_ready_q <= (w_state_next == W_IDLE);
      if (aw_hs) begin
        w_id       <= S_AXI_AWID;
        w_idx      <= S_AXI_AWADDR[IW+1:2];
        w_len      <= S_AXI_AWLEN;
        w_cnt      <= 8'd0;
        w_err      <= burst_resp_err(S_AXI_AWSIZE, S_AXI_AWBURST);
        w_size_err <= (S_AXI_AWSIZE != SIZE_4B);
        w_fixed    <= (S_AXI_AWBURST == BURST_FIXED);
        w_last_err <= 1'b0;
      end
      if (w_hs) begin
        if (S_AXI_WLAST != (w_cnt == w_len)) w_last_err <= 1'b1;
        if (w_cnt != w_len) begin
          w_cnt <= w_cnt + 8'd1;
          if (!w_fixed) w_idx <= w_idx + IW'(1);
        end
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ar_ready_q <= 1'b0;
      r_id       <= '0;
      r_idx      <= '0;
      r_len      <= 8'd0;
      r_cnt      <= 8'd0;
      r_err      <= 1'b0;
      r_size_err <= 1'b0;
      r_fixed    <= 1'b0;
    end else begin
      ar_ready_q <= (r_state_next == R_IDLE);
      if (ar_hs) begin
        r_id       <= S_AXI_ARID;
        r_idx      <= S_AXI_ARADDR[IW+1:2];
        r_len      <= S_AXI_ARLEN;
        r_cnt      <= 8'd0;
        r_err      <= burst_resp_err(S_AXI_ARSIZE, S_AXI_ARBURST);
        r_size_err <= (S_AXI_ARSIZE != SIZE_4B);
        r_fixed    <= (S_AXI_ARBURST == BURST_FIXED);
      end
      if (r_hs && !r_last) begin
        r_cnt <= r_cnt + 8'd1;
        if (!r_fixed) r_idx <= r_idx + IW'(1);
      end
    end
  end

  axi_ram_array #(.C_MEM_WORDS_LOG2(C_MEM_WORDS_LOG2)) u_array (
    .clk_sys (ACLK),
    .rst_b   (ARESETN),
    .wr_en   (w_hs && !w_size_err),
    .wr_idx  (w_idx),
    .wr_data (S_AXI_WDATA),
    .wr_strb (S_AXI_WSTRB),
    .rd_en   (rd_en),
    .rd_idx  (r_idx),
    .rd_data (ram_rdata)
  );

  assign S_AXI_AWREADY = aw_ready_q;
  assign S_AXI_WREADY  = wready;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BID     = w_id;
  assign S_AXI_BRESP   = (w_err || w_last_err) ? RESP_SLVERR : RESP_OKAY;

  assign S_AXI_ARREADY = ar_ready_q;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RID     = r_id;
  assign S_AXI_RDATA   = r_size_err ? 32'h0 : ram_rdata;
  assign S_AXI_RRESP   = r_err ? RESP_SLVERR : RESP_OKAY;
  assign S_AXI_RLAST   = rvalid && r_last;

endmodule

// File: tb/tb_axi_ram_responder.sv
// Randomized bench for axi_ram_responder against a word-array reference model.
module tb_axi_ram_responder;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [0:0]  S_AXI_AWID, S_AXI_BID, S_AXI_ARID, S_AXI_RID;
  logic [31:0] S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WDATA, S_AXI_RDATA;
  logic [7:0]  S_AXI_AWLEN, S_AXI_ARLEN;
  logic [2:0]  S_AXI_AWSIZE, S_AXI_ARSIZE;
  logic [1:0]  S_AXI_AWBURST, S_AXI_ARBURST, S_AXI_BRESP, S_AXI_RRESP;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WLAST, S_AXI_WVALID, S_AXI_WREADY;
  logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic        S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY;

  always #5 ACLK = ~ACLK;

  axi_ram_responder dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
    .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
    .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] model_mem [1024];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic int word_idx(input logic [31:0] addr, input logic [1:0] burst, input int beat);
    return (int'(addr[11:2]) + ((burst == 2'b00) ? 0 : beat)) % 1024;
  endfunction

  // Beat i takes wd[i]/ws[i]; WLAST is driven on beat last_pos.
  task automatic write_burst(input logic [0:0] id, input logic [31:0] addr, input int len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input int last_pos, input int b_stall, input bit bubbles);
    int n;
    bit err;
    S_AXI_AWID = id; S_AXI_AWADDR = addr; S_AXI_AWLEN = len[7:0];
    S_AXI_AWSIZE = size; S_AXI_AWBURST = burst; S_AXI_AWVALID = 1'b1;
    n = 0;
    while (!S_AXI_AWREADY && n < 50) begin @(posedge ACLK); #1; n++; end
    chk("awready", S_AXI_AWREADY, 1);
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0;
    chk("wready_latency", S_AXI_WREADY, 1);
    chk("awready_busy", S_AXI_AWREADY, 0);
    err = (size != 3'b010) || (burst[1] == 1'b1);
    for (int i = 0; i <= len; i++) begin
      if (bubbles && i > 0 && $urandom_range(3) == 0) begin
        S_AXI_WVALID = 1'b0;
        @(posedge ACLK); #1;
      end
      S_AXI_WDATA = wd[i]; S_AXI_WSTRB = ws[i]; S_AXI_WLAST = (i == last_pos);
      S_AXI_WVALID = 1'b1;
      n = 0;
      while (!S_AXI_WREADY && n < 50) begin @(posedge ACLK); #1; n++; end
      chk("wready", S_AXI_WREADY, 1);
      @(posedge ACLK); #1;
      if (size == 3'b010) begin
        for (int b = 0; b < 4; b++)
          if (ws[i][b]) model_mem[word_idx(addr, burst, i)][b*8 +: 8] = wd[i][b*8 +: 8];
      end
      if ((i == last_pos) != (i == len)) err = 1'b1;
    end
    S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
    chk("bvalid_latency", S_AXI_BVALID, 1);
    for (int k = 0; k < b_stall; k++) begin
      @(posedge ACLK); #1;
      chk("bvalid_hold", S_AXI_BVALID, 1);
      chk("bid_hold", S_AXI_BID, id);
    end
    chk("bid", S_AXI_BID, id);
    chk("bresp", S_AXI_BRESP, err ? 2'b10 : 2'b00);
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
    chk("bvalid_drop", S_AXI_BVALID, 0);
    chk("awready_back", S_AXI_AWREADY, 1);
  endtask

  task automatic read_burst(input logic [0:0] id, input logic [31:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int stall_max, input bit exact, output logic [31:0] last_data);
    int n, stall;
    bit err;
    logic [31:0] exp;
    last_data = 32'h0;
    S_AXI_ARID = id; S_AXI_ARADDR = addr; S_AXI_ARLEN = len[7:0];
    S_AXI_ARSIZE = size; S_AXI_ARBURST = burst; S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!S_AXI_ARREADY && n < 50) begin @(posedge ACLK); #1; n++; end
    chk("arready", S_AXI_ARREADY, 1);
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    chk("arready_busy", S_AXI_ARREADY, 0);
    err = (size != 3'b010) || (burst[1] == 1'b1);
    for (int i = 0; i <= len; i++) begin
      n = 0;
      while (!S_AXI_RVALID && n < 50) begin @(posedge ACLK); #1; n++; end
      chk("rvalid", S_AXI_RVALID, 1);
      chk("rvalid_gap", n, 1);
      exp = (size == 3'b010) ? model_mem[word_idx(addr, burst, i)] : 32'h0;
      chk("rdata", S_AXI_RDATA, exp);
      chk("rresp", S_AXI_RRESP, err ? 2'b10 : 2'b00);
      chk("rlast", S_AXI_RLAST, (i == len));
      chk("rid", S_AXI_RID, id);
      last_data = S_AXI_RDATA;
      stall = exact ? stall_max : int'($urandom_range(stall_max));
      for (int k = 0; k < stall; k++) begin
        @(posedge ACLK); #1;
        chk("rvalid_hold", S_AXI_RVALID, 1);
        chk("rdata_hold", S_AXI_RDATA, exp);
        chk("rid_hold", S_AXI_RID, id);
      end
      S_AXI_RREADY = 1'b1;
      @(posedge ACLK); #1;
      S_AXI_RREADY = 1'b0;
    end
    chk("rvalid_drop", S_AXI_RVALID, 0);
    chk("arready_back", S_AXI_ARREADY, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, d2;
    int n, wlen, rlen, wpos;
    logic [2:0] wsz, rsz;
    logic [1:0] wbu, rbu;

    ARESETN = 1'b0;
    S_AXI_AWID = '0; S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWSIZE = '0;
    S_AXI_AWBURST = '0; S_AXI_AWVALID = 1'b0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
    S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARID = '0; S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARSIZE = '0;
    S_AXI_ARBURST = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;

    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_awready", S_AXI_AWREADY, 0);
    chk("rst_arready", S_AXI_ARREADY, 0);
    chk("rst_wready", S_AXI_WREADY, 0);
    chk("rst_bvalid", S_AXI_BVALID, 0);
    chk("rst_rvalid", S_AXI_RVALID, 0);
    chk("rst_bresp", S_AXI_BRESP, 0);
    chk("rst_rresp", S_AXI_RRESP, 0);
    chk("rst_rlast", S_AXI_RLAST, 0);
    chk("rst_rdata", S_AXI_RDATA, 0);
    chk("rst_bid", S_AXI_BID, 0);
    chk("rst_rid", S_AXI_RID, 0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    #1;
    chk("awready_before_edge", S_AXI_AWREADY, 0);
    @(posedge ACLK); #1;
    chk("awready_first_edge", S_AXI_AWREADY, 1);
    chk("arready_first_edge", S_AXI_ARREADY, 1);

    // Fill the whole RAM so every later read has a defined expectation.
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      write_burst(1'b0, blk * 1024, 255, 3'b010, 2'b01, 255, 0, 1'b0);
    end

    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    write_burst(1'b1, 32'h10, 0, 3'b010, 2'b01, 0, 0, 1'b0);
    read_burst(1'b1, 32'h10, 0, 3'b010, 2'b01, 0, 1'b0, d);
    chk("single_rdata", d, 32'hDEADBEEF);

    for (int i = 0; i < 4; i++) begin wd[i] = i + 1; ws[i] = 4'hF; end
    write_burst(1'b0, 32'h100, 3, 3'b010, 2'b01, 3, 0, 1'b0);
    read_burst(1'b0, 32'h100, 3, 3'b010, 2'b01, 0, 1'b0, d);
    chk("incr_last_rdata", d, 32'd4);

    wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
    write_burst(1'b0, 32'h200, 0, 3'b010, 2'b01, 0, 0, 1'b0);
    wd[0] = 32'h11223344; ws[0] = 4'b0101;
    write_burst(1'b0, 32'h200, 0, 3'b010, 2'b01, 0, 0, 1'b0);
    read_burst(1'b0, 32'h200, 0, 3'b010, 2'b01, 0, 1'b0, d);
    chk("strobe_merge", d, 32'hFF22FF44);

    for (int i = 0; i < 3; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    write_burst(1'b1, 32'h300, 2, 3'b010, 2'b01, 1, 0, 1'b0);
    read_burst(1'b1, 32'h300, 2, 3'b010, 2'b01, 1, 1'b0, d);
    chk("early_wlast_beat2", d, wd[2]);
    wd[0] = 32'hA5A5A5A5; ws[0] = 4'hF;
    write_burst(1'b0, 32'h300, 0, 3'b001, 2'b01, 0, 0, 1'b0);
    read_burst(1'b0, 32'h300, 0, 3'b010, 2'b01, 0, 1'b0, d);
    read_burst(1'b1, 32'h300, 1, 3'b001, 2'b01, 0, 1'b0, d);
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    write_burst(1'b1, 32'hFF8, 3, 3'b010, 2'b10, 3, 0, 1'b0);
    read_burst(1'b1, 32'hFF8, 3, 3'b010, 2'b11, 0, 1'b0, d);
    write_burst(1'b0, 32'h340, 3, 3'b010, 2'b00, 3, 0, 1'b1);
    read_burst(1'b0, 32'h340, 1, 3'b010, 2'b00, 0, 1'b0, d);

    for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    fork
      write_burst(1'b1, 32'h400, 7, 3'b010, 2'b01, 7, 5, 1'b0);
      read_burst(1'b0, 32'h100, 3, 3'b010, 2'b01, 5, 1'b1, d2);
    join
    read_burst(1'b1, 32'h400, 7, 3'b010, 2'b01, 0, 1'b0, d);

    // Reset asserted while beat 2 of a 4-beat read is presented.
    S_AXI_ARID = 1'b1; S_AXI_ARADDR = 32'h100; S_AXI_ARLEN = 8'd3;
    S_AXI_ARSIZE = 3'b010; S_AXI_ARBURST = 2'b01; S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!S_AXI_ARREADY && n < 50) begin @(posedge ACLK); #1; n++; end
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!S_AXI_RVALID && n < 50) begin @(posedge ACLK); #1; n++; end
    S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b0;
    n = 0;
    while (!S_AXI_RVALID && n < 50) begin @(posedge ACLK); #1; n++; end
    chk("abort_beat2_valid", S_AXI_RVALID, 1);
    chk("abort_beat2_data", S_AXI_RDATA, 32'd2);
    #2 ARESETN = 1'b0;
    #1;
    chk("abort_rvalid", S_AXI_RVALID, 0);
    chk("abort_rlast", S_AXI_RLAST, 0);
    chk("abort_rdata", S_AXI_RDATA, 0);
    chk("abort_rid", S_AXI_RID, 0);
    chk("abort_arready", S_AXI_ARREADY, 0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    #1;
    chk("abort_arready_pre", S_AXI_ARREADY, 0);
    @(posedge ACLK); #1;
    chk("abort_arready_post", S_AXI_ARREADY, 1);
    chk("abort_no_rvalid", S_AXI_RVALID, 0);
    read_burst(1'b0, 32'h100, 3, 3'b010, 2'b01, 1, 1'b0, d);
    chk("after_abort_last", d, 32'd4);

    // Concurrent random bursts on disjoint halves of the RAM.
    for (int it = 0; it < 30; it++) begin
      wlen = $urandom_range(15);
      rlen = $urandom_range(15);
      wsz  = ($urandom_range(7) == 0) ? 3'b001 : 3'b010;
      rsz  = ($urandom_range(7) == 0) ? 3'b001 : 3'b010;
      wbu  = 2'($urandom_range(3));
      rbu  = 2'($urandom_range(3));
      wpos = ($urandom_range(5) == 0) ? int'($urandom_range(wlen)) : wlen;
      for (int i = 0; i <= wlen; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom_range(15)); end
      fork
        write_burst(1'($urandom_range(1)), 32'($urandom_range(480)) << 2, wlen, wsz, wbu,
                    wpos, int'($urandom_range(3)), 1'b1);
        read_burst(1'($urandom_range(1)), 32'(512 + $urandom_range(488)) << 2, rlen, rsz, rbu,
                   3, 1'b0, d2);
      join
    end
    for (int it = 0; it < 4; it++)
      read_burst(1'b1, 32'($urandom_range(480)) << 2, 15, 3'b010, 2'b01, 1, 1'b0, d);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_ram_responder.md
# axi_ram_responder

AXI4 slave memory that answers the CPU core's AXI4 master port, serving both instruction and data accesses in simulation and small on-chip builds. It holds a word-addressed byte-writable RAM and runs independent write (AW/W/B) and read (AR/R) engines. Each engine handles one burst at a time. It sits on the interconnect opposite the core, sharing its ACLK/ARESETN domain.

## Interface
- C_S_AXI_ID_WIDTH, 1: AWID/ARID/BID/RID width
- C_S_AXI_ADDR_WIDTH, 32: address width
- C_S_AXI_DATA_WIDTH, 32: data width; only 32 supported
- C_MEM_WORDS_LOG2, 10: RAM depth is 2^C_MEM_WORDS_LOG2 32-bit words
- ACLK  in  1  single clock; everything samples on rising edge
- ARESETN  in  1  asynchronous, active-low reset
- S_AXI_AWID / AWADDR / AWLEN(8) / AWSIZE(3) / AWBURST(2) / AWVALID  in; S_AXI_AWREADY  out
- S_AXI_WDATA(32) / WSTRB(4) / WLAST / WVALID  in; S_AXI_WREADY  out
- S_AXI_BID / BRESP(2) / BVALID  out; S_AXI_BREADY  in
- S_AXI_ARID / ARADDR / ARLEN(8) / ARSIZE(3) / ARBURST(2) / ARVALID  in; S_AXI_ARREADY  out
- S_AXI_RID / RDATA(32) / RRESP(2) / RLAST / RVALID  out; S_AXI_RREADY  in
- LOCK/CACHE/PROT/QOS/USER signals are not ported; the integrator leaves the master's outputs unconnected.

## Operation
- Word index is addr[C_MEM_WORDS_LOG2+1:2]. Higher address bits alias, with no decode error.
- Burst address rules:
  - INCR: index +1 per beat, wrapping modulo depth.
  - FIXED: index is held.
  - WRAP or reserved: handled as INCR, response SLVERR.
- AxSIZE != 3'b010: response SLVERR for the whole burst. Writes to memory are suppressed and read data is 0.
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: AWREADY=1. An AW handshake latches ID, index, LEN, error flag and clears the beat counter.
  - W_DATA: WREADY=1. Each W handshake writes the bytes enabled by WSTRB.
  - The burst ends on the beat where the counter equals AWLEN; WLAST does not end it.
  - If WLAST disagrees with the counter on any beat, BRESP=SLVERR. All data is still written.
  - W_RESP: BVALID=1 with BID = latched ID. Return to W_IDLE on BREADY.
- Read FSM: R_IDLE -> R_FETCH -> R_DATA -> (R_FETCH | R_IDLE).
  - R_IDLE: ARREADY=1. An AR handshake latches ID, index, LEN and error flag.
  - R_FETCH: registered RAM read into RDATA.
  - R_DATA: RVALID=1, with RLAST=1 on beat ARLEN. RDATA/RRESP/RLAST/RID hold until RREADY.
  - On a handshake: non-last beat -> R_FETCH; last beat -> R_IDLE.
- The two engines run fully concurrently. A same-cycle write and fetch of the same word returns the old contents (read-before-write).
- RAM contents are not reset.

## Timing
- Reset values:
  - All READY/VALID = 0.
  - BRESP/RRESP = 2'b00; RLAST = 0; RDATA = 0; BID/RID = 0.
  - States W_IDLE/R_IDLE.
- AWREADY/ARREADY are registered. They first assert on the first rising edge after ARESETN deasserts.
- Write latency:
  - AW handshake at edge N gives WREADY from N+1.
  - Last W handshake at edge M gives BVALID from M+1.
  - Throughput 1 beat/cycle.
- Read latency:
  - AR handshake at edge N gives RVALID from N+2.
  - Each subsequent beat is valid 2 cycles after the previous handshake, so throughput is 1 beat per 2 cycles.
- AWREADY is 0 outside W_IDLE and ARREADY is 0 outside R_IDLE: one outstanding burst per direction.
- The VALID-before-READY rule is met: no output VALID depends combinationally on an input READY.
- ARESETN asserted mid-burst:
  - Immediately forces the reset values.
  - Partially written bursts are retained in RAM.
  - No B or R response is issued for the aborted burst.

## Structure
- Package axi_ram_pkg holds:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - BURST_FIXED=2'b00, BURST_INCR=2'b01, BURST_WRAP=2'b10
  - SIZE_4B=3'b010
  - the write and read state enums
- Sub-module axi_ram_array: one byte-enabled write port and one registered read port, parameterised by C_MEM_WORDS_LOG2.

## Test plan
- Single write AWADDR=0x10, WDATA=0xDEADBEEF, WSTRB=4'hF, then single read at 0x10 -> BRESP=OKAY, BID echoed; RDATA=0xDEADBEEF with RLAST=1 and RRESP=OKAY.
- INCR write of 4 beats (AWLEN=3) at 0x100 with data 1..4, then INCR read ARLEN=3 -> RDATA 1,2,3,4; RLAST only on the 4th beat; RVALID gaps as specified.
- Byte strobes: write 0x11223344 with WSTRB=4'b0101 over 0xFFFFFFFF -> read returns 0xFF22FF44.
- Early WLAST on beat 1 of AWLEN=2 -> three beats accepted, BRESP=SLVERR; AWSIZE=3'b001 -> SLVERR and memory unchanged.
- Backpressure: BREADY and RREADY held low 5 cycles -> BVALID/RVALID, data and RID held stable; concurrent write and read bursts both complete.
- ARESETN pulsed low during beat 2 of a 4-beat read -> RVALID=0 immediately; ARREADY=1 one cycle after release; a new read then succeeds.
